// File: rtl/simmem_pkg.sv
// Shared types for the simulated-memory response bank: per-slot delay tracking state
// and the default widths the bank is built with.
package simmem_pkg;

  localparam int unsigned DefaultIDWidth    = 8;
  localparam int unsigned DefaultNumSlots   = 32;
  localparam int unsigned DefaultDelayWidth = 6;

  typedef struct packed {
    logic                         valid;
    logic [DefaultIDWidth-1:0]    id;
    logic [DefaultDelayWidth-1:0] counter;
  } slot_t;

  // A slot may be released once its countdown has bottomed out.
  function automatic logic slot_expired(slot_t s);
    return s.valid && (s.counter == '0);
  endfunction

endpackage

// File: rtl/simmem_lowest_one_finder.sv
// Priority select: one-hot and binary index of the lowest set bit of in_i.
// Both outputs are zero when no bit is set.
module simmem_lowest_one_finder #(
  parameter  int unsigned Width = 4,
  localparam int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] onehot_o,
  output logic [IdxW-1:0]  idx_o
);

  // Scanning downward lets the lowest set bit overwrite any higher candidate.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/simmem_delay_releaser.sv
// Release-side scheduler for the simulated-memory response bank: holds one countdown per
// outstanding request and raises release_en_o[id] while an expired slot of that ID exists.
module simmem_delay_releaser
  import simmem_pkg::*;
#(
  parameter int unsigned IDWidth    = DefaultIDWidth,
  parameter int unsigned NumSlots   = DefaultNumSlots,
  parameter int unsigned DelayWidth = DefaultDelayWidth
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [IDWidth-1:0]        req_id_i,
  input  logic [DelayWidth-1:0]     req_delay_i,
  output logic [2**IDWidth-1:0]     release_en_o,
  input  logic                      rsp_done_i,
  input  logic [IDWidth-1:0]        rsp_id_i,
  output logic [$clog2(NumSlots):0] slots_used_o
);

  localparam int unsigned IdxW = $clog2(NumSlots);
  localparam int unsigned CntW = $clog2(NumSlots) + 1;

  slot_t slot_q [NumSlots];
  slot_t slot_d [NumSlots];

  logic [NumSlots-1:0]  free_vec;
  logic [NumSlots-1:0]  match_vec;
  logic [NumSlots-1:0]  alloc_oh;
  logic [NumSlots-1:0]  free_oh;
  logic [IdxW-1:0]      alloc_idx;
  logic [IdxW-1:0]      free_idx;
  logic                 free_hit;
  logic                 req_fire;
  logic [2**IDWidth-1:0] release_en;
  logic [CntW-1:0]      used;
  logic                 unused_sel;

  always_comb begin
    free_vec  = '0;
    match_vec = '0;
    for (int i = 0; i < NumSlots; i++) begin
      free_vec[i]  = !slot_q[i].valid;
      match_vec[i] = slot_expired(slot_q[i]) && (slot_q[i].id == rsp_id_i);
    end
  end

  simmem_lowest_one_finder #(.Width(NumSlots)) u_alloc_sel (
    .in_i     (free_vec),
    .onehot_o (alloc_oh),
    .idx_o    (alloc_idx)
  );

  simmem_lowest_one_finder #(.Width(NumSlots)) u_free_sel (
    .in_i     (match_vec),
    .onehot_o (free_oh),
    .idx_o    (free_idx)
  );

  assign unused_sel = ^{alloc_oh, free_idx};

  // Ready depends only on registered occupancy, so a slot freed this edge is not reused.
  assign req_ready_o = |free_vec;
  assign free_hit    = |match_vec;
  assign req_fire    = req_valid_i && req_ready_o;

  always_comb begin
    slot_d     = slot_q;
    release_en = '0;
    used       = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (slot_expired(slot_q[i])) begin
        release_en[slot_q[i].id] = 1'b1;
      end
      used = used + CntW'(slot_q[i].valid);
      if (slot_q[i].valid && (slot_q[i].counter != '0)) begin
        slot_d[i].counter = slot_q[i].counter - 1'b1;
      end
      if (rsp_done_i && free_hit && free_oh[i]) begin
        slot_d[i] = '0;
      end
    end
    // Allocation targets a free slot, freeing an occupied one, so the two never collide.
    if (req_fire) begin
      slot_d[alloc_idx].valid   = 1'b1;
      slot_d[alloc_idx].id      = req_id_i;
      slot_d[alloc_idx].counter = req_delay_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign release_en_o = release_en;
  assign slots_used_o = used;

`ifndef SYNTHESIS
  // A completion with nothing to retire points at a bank/releaser disagreement; reported, not fatal.
  a_done_has_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_done_i |-> free_hit)
    else $warning("rsp_done_i for id %0d has no expired slot", rsp_id_i);

  a_used_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    slots_used_o <= CntW'(NumSlots));

  a_empty_quiet: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slots_used_o == '0) |-> (release_en_o == '0));
`endif

endmodule

// File: tb/tb_simmem_delay_releaser.sv
// Scoreboard bench for simmem_delay_releaser: each accepted request records the cycle its
// release bit must rise; the queue is drained as the clock advances.
module tb_simmem_delay_releaser;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [7:0]   req_id_i = '0;
  logic [5:0]   req_delay_i = '0;
  logic [255:0] release_en_o;
  logic         rsp_done_i = 1'b0;
  logic [7:0]   rsp_id_i = '0;
  logic [5:0]   slots_used_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int id;
    int due;
    bit chk_prev;
  } exp_t;

  exp_t sb[$];
  logic [255:0] prev_rel;

  simmem_delay_releaser dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_id_i     (req_id_i),
    .req_delay_i  (req_delay_i),
    .release_en_o (release_en_o),
    .rsp_done_i   (rsp_done_i),
    .rsp_id_i     (rsp_id_i),
    .slots_used_o (slots_used_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Advance one edge, sample 1ns later, and retire every expectation due this cycle.
  task automatic sb_step();
    exp_t keep[$];
    prev_rel = release_en_o;
    @(posedge clk_i);
    #1;
    keep = {};
    foreach (sb[j]) begin
      if (sb[j].due <= cyc) begin
        checks++;
        if (sb[j].due != cyc || release_en_o[sb[j].id] !== 1'b1 ||
            (sb[j].chk_prev && prev_rel[sb[j].id] !== 1'b0)) begin
          errors++;
          $display("FAIL release id=%0d cyc=%0d due=%0d got now=%b prev=%b need now=1 prev=0",
                   sb[j].id, cyc, sb[j].due, release_en_o[sb[j].id], prev_rel[sb[j].id]);
        end
      end else begin
        keep.push_back(sb[j]);
      end
    end
    sb = keep;
  endtask

  task automatic issue(input int id, input int dly, input bit chk_prev, input bit track);
    req_valid_i = 1'b1;
    req_id_i    = 8'(id);
    req_delay_i = 6'(dly);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready id=%0d got %b need 1", id, req_ready_o);
    end
    if (track) sb.push_back(exp_t'{id: id, due: cyc + 1 + dly, chk_prev: chk_prev});
    sb_step();
    req_valid_i = 1'b0;
  endtask

  task automatic done(input int id);
    rsp_done_i = 1'b1;
    rsp_id_i   = 8'(id);
    sb_step();
    rsp_done_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && sb.size() > 0; n++) sb_step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d need 0", sb.size());
      sb = {};
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b need 1", req_ready_o); end
    checks++;
    if (release_en_o !== '0) begin errors++; $display("FAIL reset_release got %h need 0", release_en_o); end
    checks++;
    if (slots_used_o !== 6'd0) begin errors++; $display("FAIL reset_used got %0d need 0", slots_used_o); end
  endtask

  task automatic test_delay0();
    issue(3, 0, 1'b1, 1'b1);
    checks++;
    if (slots_used_o !== 6'd1) begin errors++; $display("FAIL d0_used got %0d need 1", slots_used_o); end
    drain(2);
    done(3);
    checks++;
    if (release_en_o[3] !== 1'b0) begin errors++; $display("FAIL d0_free_bit got %b need 0", release_en_o[3]); end
    checks++;
    if (slots_used_o !== 6'd0) begin errors++; $display("FAIL d0_free_used got %0d need 0", slots_used_o); end
  endtask

  task automatic test_two_ids();
    issue(5, 4, 1'b1, 1'b1);
    issue(7, 1, 1'b1, 1'b1);
    drain(10);
    checks++;
    if (release_en_o[7] !== 1'b1 || release_en_o[5] !== 1'b1) begin
      errors++; $display("FAIL two_both got b7=%b b5=%b need 1 1", release_en_o[7], release_en_o[5]);
    end
    done(7);
    checks++;
    if (release_en_o[7] !== 1'b0 || release_en_o[5] !== 1'b1) begin
      errors++; $display("FAIL two_free7 got b7=%b b5=%b need 0 1", release_en_o[7], release_en_o[5]);
    end
    done(5);
    checks++;
    if (slots_used_o !== 6'd0 || release_en_o !== '0) begin
      errors++; $display("FAIL two_empty got used=%0d rel=%h need 0 0", slots_used_o, release_en_o);
    end
  endtask

  task automatic test_same_id();
    issue(2, 3, 1'b1, 1'b1);
    issue(2, 3, 1'b0, 1'b1);
    drain(10);
    checks++;
    if (slots_used_o !== 6'd2) begin errors++; $display("FAIL same_used2 got %0d need 2", slots_used_o); end
    done(2);
    checks++;
    if (release_en_o[2] !== 1'b1 || slots_used_o !== 6'd1) begin
      errors++; $display("FAIL same_first got bit=%b used=%0d need 1 1", release_en_o[2], slots_used_o);
    end
    done(2);
    checks++;
    if (release_en_o[2] !== 1'b0 || slots_used_o !== 6'd0) begin
      errors++; $display("FAIL same_second got bit=%b used=%0d need 0 0", release_en_o[2], slots_used_o);
    end
  endtask

  task automatic test_full();
    int due0;
    for (int i = 0; i < 32; i++) issue(16 + i, 63, 1'b1, 1'b1);
    due0 = sb[0].due;
    checks++;
    if (req_ready_o !== 1'b0 || slots_used_o !== 6'd32) begin
      errors++; $display("FAIL full_state got ready=%b used=%0d need 0 32", req_ready_o, slots_used_o);
    end
    // Upstream holds its request while the bank is full.
    req_valid_i = 1'b1;
    req_id_i    = 8'd200;
    req_delay_i = 6'd0;
    for (int n = 0; n < 100 && cyc < due0; n++) sb_step();
    checks++;
    if (req_ready_o !== 1'b0 || slots_used_o !== 6'd32) begin
      errors++; $display("FAIL full_hold got ready=%b used=%0d need 0 32", req_ready_o, slots_used_o);
    end
    done(16);
    checks++;
    if (req_ready_o !== 1'b1 || slots_used_o !== 6'd31) begin
      errors++; $display("FAIL full_freed got ready=%b used=%0d need 1 31", req_ready_o, slots_used_o);
    end
    sb.push_back(exp_t'{id: 200, due: cyc + 1, chk_prev: 1'b1});
    sb_step();
    req_valid_i = 1'b0;
    checks++;
    if (req_ready_o !== 1'b0 || slots_used_o !== 6'd32) begin
      errors++; $display("FAIL full_refill got ready=%b used=%0d need 0 32", req_ready_o, slots_used_o);
    end
    drain(200);
    for (int i = 1; i < 32; i++) done(16 + i);
    done(200);
    checks++;
    if (slots_used_o !== 6'd0 || release_en_o !== '0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL full_empty got used=%0d rel=%h ready=%b need 0 0 1",
                         slots_used_o, release_en_o, req_ready_o);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) issue(100 + i, 0, 1'b1, 1'b1);
    for (int i = 5; i < 10; i++) issue(100 + i, 20, 1'b1, 1'b0);
    drain(3);
    checks++;
    if (slots_used_o !== 6'd10) begin errors++; $display("FAIL ar_used got %0d need 10", slots_used_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || release_en_o !== '0 || slots_used_o !== 6'd0) begin
      errors++; $display("FAIL ar_async got ready=%b rel=%h used=%0d need 1 0 0",
                         req_ready_o, release_en_o, slots_used_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    issue(9, 40, 1'b1, 1'b0);
    // Completion for an ID whose only slot is still counting must leave everything alone.
    done(9);
    checks++;
    if (slots_used_o !== 6'd1 || release_en_o !== '0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL ar_nomatch got used=%0d rel=%h ready=%b need 1 0 1",
                         slots_used_o, release_en_o, req_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_delay0();
    test_two_ids();
    test_same_id();
    test_full();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
